// File: rtl/riscv_pkg.sv
// Shared pipeline encodings: result-select and forward-select codes, default register index width.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Purpose: tracks destination registers of outstanding long-latency ops (pending bits + count).
// Latency: issue/completion visible on pending and sb_full one cycle later (registered).
// Backpressure: none internal; the caller must not issue while sb_full or the destination is pending.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int MAX_PENDING = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_vld,
    input  logic [REG_ADDR_W-1:0]        issue_rd,
    input  logic                         done_vld,
    input  logic [REG_ADDR_W-1:0]        done_rd,
    output logic [(1<<REG_ADDR_W)-1:0]   pending,
    output logic                         sb_full
);
    import riscv_pkg::*;

    localparam int CW = $clog2(MAX_PENDING + 1);

    logic [CW-1:0]               count;
    logic [CW-1:0]               count_nxt;
    logic [(1<<REG_ADDR_W)-1:0]  pending_nxt;
    logic                        done_hit;

    always_comb begin
        // completions for registers that are not pending are dropped, so count never underflows
        done_hit    = done_vld & pending[done_rd];
        pending_nxt = pending;
        count_nxt   = count;
        if (done_hit)
            pending_nxt[done_rd] = 1'b0;
        if (issue_vld)
            pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
        case ({issue_vld, done_hit})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            count   <= '0;
            sb_full <= 1'b0;
        end else begin
            pending <= pending_nxt;
            count   <= count_nxt;
            sb_full <= (count_nxt == CW'(MAX_PENDING));
        end
    end

endmodule

// File: rtl/hazard_unit_sb.sv
// Purpose: pipeline hazard unit (load-use, long-op scoreboard, branch flush, memory-busy freeze, forwarding).
// Latency: stall/flush/forward outputs are combinational; scoreboard state updates at the next edge.
// Backpressure: MemBusyM freezes every stage; a branch seen while frozen is flushed on the first free cycle.
// Optional perf counters enabled by HAZARD_UNIT_PERF_EN.
module hazard_unit_sb #(
    parameter int REG_ADDR_W  = riscv_pkg::REG_ADDR_W,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  UsesRs1D,
    input  logic                  UsesRs2D,
    input  logic                  RegWriteD,
    input  logic                  LongOpD,
    input  logic [1:0]            ResultSrcE,
    input  logic                  PCSrcE,
    input  logic                  RegWriteE,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  RegWriteM,
    input  logic                  MemBusyM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  LongDoneValid,
    input  logic [REG_ADDR_W-1:0] LongDoneRd,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  SbFull,
    output logic [CNT_W-1:0]      StallCycles,
    output logic [CNT_W-1:0]      FlushCycles
);
    import riscv_pkg::*;

    logic [(1<<REG_ADDR_W)-1:0] pending;
    logic lw_stall;
    logic sb_stall;
    logic hold_d;
    logic flush_pend;
    logic flush_req;
    logic issue_vld;
    logic unused_ok;

    assign unused_ok = RegWriteE;

    hazard_scoreboard #(
        .REG_ADDR_W  (REG_ADDR_W),
        .MAX_PENDING (MAX_PENDING)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .issue_vld (issue_vld),
        .issue_rd  (RdD),
        .done_vld  (LongDoneValid),
        .done_rd   (LongDoneRd),
        .pending   (pending),
        .sb_full   (SbFull)
    );

    assign lw_stall = (ResultSrcE == RESULT_MEM) && (RdE != '0) &&
                      ((UsesRs1D && Rs1D == RdE) || (UsesRs2D && Rs2D == RdE));

    // scoreboard terms are forced off while reset is asserted
    assign sb_stall = !reset && ((UsesRs1D && pending[Rs1D]) ||
                                 (UsesRs2D && pending[Rs2D]) ||
                                 (LongOpD && RegWriteD && pending[RdD]) ||
                                 (LongOpD && SbFull));

    assign hold_d    = lw_stall || sb_stall;
    assign flush_req = PCSrcE || (flush_pend && !reset);

    always_comb begin
        StallF = hold_d;
        StallD = hold_d;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = flush_req;
        FlushE = hold_d || flush_req;
        FlushW = 1'b0;
        if (MemBusyM) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    assign issue_vld = LongOpD && RegWriteD && (RdD != '0) && !StallD && !FlushE && !MemBusyM;

    // remembers a taken branch that arrived while memory was busy
    always_ff @(posedge clk) begin
        if (reset)
            flush_pend <= 1'b0;
        else
            flush_pend <= MemBusyM && flush_req;
    end

    always_comb begin
        ForwardAE = FWD_NONE;
        if (RegWriteM && RdM == Rs1E && Rs1E != '0)
            ForwardAE = FWD_MEM;
        else if (RegWriteW && RdW == Rs1E && Rs1E != '0)
            ForwardAE = FWD_WB;
        ForwardBE = FWD_NONE;
        if (RegWriteM && RdM == Rs2E && Rs2E != '0)
            ForwardBE = FWD_MEM;
        else if (RegWriteW && RdW == Rs2E && Rs2E != '0)
            ForwardBE = FWD_WB;
    end

`ifdef HAZARD_UNIT_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles <= '0;
            FlushCycles <= '0;
        end else begin
            if (StallD && StallCycles != '1)
                StallCycles <= StallCycles + CNT_W'(1);
            if ((FlushD || FlushE) && FlushCycles != '1)
                FlushCycles <= FlushCycles + CNT_W'(1);
        end
    end
`else
    assign StallCycles = '0;
    assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb; driver queues expected outputs, a negedge monitor compares.
module tb_hazard_unit_sb;

    localparam int AW = 5;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd;
    logic UsesRs1D, UsesRs2D, RegWriteD, LongOpD, PCSrcE, RegWriteE;
    logic RegWriteM, MemBusyM, RegWriteW, LongDoneValid;
    logic [1:0] ResultSrcE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, SbFull;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CW-1:0] StallCycles, FlushCycles;

    typedef struct packed {
        logic sf, sd, se, sm, fd, fe, fw;
        logic [1:0] fa, fb;
        logic full;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    hazard_unit_sb dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
        .RegWriteD(RegWriteD), .LongOpD(LongOpD),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteM(RegWriteM), .MemBusyM(MemBusyM), .RdM(RdM),
        .RegWriteW(RegWriteW), .RdW(RdW),
        .LongDoneValid(LongDoneValid), .LongDoneRd(LongDoneRd),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .SbFull(SbFull),
        .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic sf, sd, se, sm, fd, fe, fw,
                                input logic [1:0] fa, fb, input logic full);
        obs_t o;
        o.sf = sf; o.sd = sd; o.se = se; o.sm = sm;
        o.fd = fd; o.fe = fe; o.fw = fw;
        o.fa = fa; o.fb = fb; o.full = full;
        return o;
    endfunction

    function automatic obs_t hold(input logic full);
        return mk(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, full);
    endfunction

    function automatic obs_t clr(input logic full);
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, full);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("sF%b sD%b sE%b sM%b fD%b fE%b fW%b fwdA%b fwdB%b full%b",
                         o.sf, o.sd, o.se, o.sm, o.fd, o.fe, o.fw, o.fa, o.fb, o.full);
    endfunction

    task automatic expect_o(input string nm, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = '0; Rs2D = '0; RdD = '0; UsesRs1D = 0; UsesRs2D = 0;
        RegWriteD = 0; LongOpD = 0; ResultSrcE = 2'b00; PCSrcE = 0; RegWriteE = 0;
        Rs1E = '0; Rs2E = '0; RdE = '0; RegWriteM = 0; MemBusyM = 0; RdM = '0;
        RegWriteW = 0; RdW = '0; LongDoneValid = 0; LongDoneRd = '0;
    endtask

    task automatic long_op(input int rd);
        LongOpD = 1; RegWriteD = 1; RdD = AW'(rd);
    endtask

    // monitor: compares every queued expectation in the cycle it was issued
    obs_t  m_exp, m_act;
    string m_name;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = mk(StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                        ForwardAE, ForwardBE, SbFull);
            n_tests++;
            if (m_act !== m_exp) begin
                n_fail++;
                $display("FAIL %s: got %s, required %s", m_name, fmt(m_act), fmt(m_exp));
            end
`ifndef HAZARD_UNIT_PERF_EN
            n_tests++;
            if (StallCycles !== '0 || FlushCycles !== '0) begin
                n_fail++;
                $display("FAIL %s_perf_tied: got stall=%0d flush=%0d, required 0/0",
                         m_name, StallCycles, FlushCycles);
            end
`endif
        end
    end

    initial begin
        reset = 1;
        idle();

        // reset behaviour
        step(); expect_o("reset_idle", clr(0));
        step(); ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; UsesRs1D = 1;
        expect_o("reset_lw_follows", hold(0));
        step(); reset = 0; idle(); expect_o("post_reset", clr(0));

        // load-use
        step(); ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; UsesRs1D = 1; expect_o("lw_stall", hold(0));
        step(); idle(); expect_o("lw_bubble", clr(0));
        step(); ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; UsesRs1D = 1; expect_o("lw_x0", clr(0));
        step(); idle(); ResultSrcE = 2'b01; RdE = 9; Rs2D = 9; UsesRs2D = 1; expect_o("lw_rs2", hold(0));
        step(); UsesRs2D = 0; expect_o("lw_unused_src", clr(0));
        step(); ResultSrcE = 2'b00; UsesRs2D = 1; expect_o("alu_no_stall", clr(0));

        // forwarding
        step(); idle(); RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3; Rs1E = 3; Rs2E = 0;
        expect_o("fwd_mem_prio", mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
        step(); RegWriteM = 0; expect_o("fwd_wb", mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
        step(); idle(); RegWriteM = 1; RegWriteW = 1;
        expect_o("fwd_x0", clr(0));
        step(); idle(); RegWriteM = 1; RdM = 6; Rs2E = 6; Rs1E = 2; RegWriteW = 1; RdW = 2;
        expect_o("fwd_both", mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0));
        step(); idle(); RdW = 4; RdM = 4; Rs1E = 4; expect_o("fwd_nowrite", clr(0));

        // long op RAW, release the cycle after completion
        step(); idle(); long_op(7); expect_o("mul_issue", clr(0));
        step(); idle(); UsesRs1D = 1; Rs1D = 7; expect_o("raw_x7_a", hold(0));
        step(); expect_o("raw_x7_b", hold(0));
        step(); LongDoneValid = 1; LongDoneRd = 7; expect_o("raw_done_same_cycle", hold(0));
        step(); LongDoneValid = 0; expect_o("raw_release", clr(0));

        // fill the scoreboard
        for (int i = 1; i <= 4; i++) begin
            step(); idle(); long_op(i); expect_o($sformatf("issue_x%0d", i), clr(0));
        end
        step(); idle(); long_op(8); expect_o("full_stall", hold(1));
        step(); LongDoneValid = 1; LongDoneRd = 2; expect_o("full_done_same_cycle", hold(1));
        step(); idle(); long_op(8); expect_o("full_issue_after_done", clr(0));
        step(); idle(); LongDoneValid = 1; LongDoneRd = 1; expect_o("full_again", clr(1));
        step(); idle(); long_op(3); LongDoneValid = 1; LongDoneRd = 20; expect_o("waw_stall", hold(0));
        step(); idle(); long_op(9); expect_o("issue_x9", clr(0));
        step(); idle(); expect_o("ignored_done_no_dec", clr(1));
        step(); LongDoneValid = 1; LongDoneRd = 8; expect_o("done_x8", clr(1));
        step(); LongDoneRd = 9; expect_o("done_x9", clr(0));

        // reset with two pending, then stray completion
        step(); reset = 1; idle(); UsesRs1D = 1; Rs1D = 3; expect_o("reset_masks_sb", clr(0));
        step(); reset = 0; LongDoneValid = 1; LongDoneRd = 1; expect_o("post_reset_no_stall", clr(0));
        step(); idle(); long_op(0); expect_o("issue_x0_ignored", clr(0));
        for (int i = 10; i <= 13; i++) begin
            step(); idle(); long_op(i); expect_o($sformatf("issue_x%0d", i), clr(0));
        end

        // memory busy with taken branch
        for (int i = 1; i <= 3; i++) begin
            step(); idle(); PCSrcE = 1; MemBusyM = 1;
            expect_o($sformatf("busy_%0d", i), mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1));
        end
        step(); MemBusyM = 0; expect_o("busy_release_flush", mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1));
        step(); idle(); expect_o("after_branch", clr(1));
        step(); PCSrcE = 1; expect_o("branch", mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1));
        step(); idle(); ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; UsesRs1D = 1; MemBusyM = 1;
        expect_o("busy_over_lw", mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1));
        step(); idle(); expect_o("final_idle", clr(1));

        step();
        step();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_sb.md
HAZARD_UNIT_SB -- requirements
Module: hazard_unit_sb

Interface
REQ-001 Parameters SHALL be: REG_ADDR_W, default 5, register index width; MAX_PENDING, default 4, outstanding long-latency writes; CNT_W, default 32, perf counter width.
REQ-002 Ports SHALL be:
- clk, in, 1, rising-edge clock
- reset, in, 1, synchronous active-high reset
- Rs1D/Rs2D/RdD, in, REG_ADDR_W, decode sources/destination
- UsesRs1D/UsesRs2D, in, 1, source actually read
- RegWriteD/LongOpD, in, 1, decode writes Rd; op is long-latency (mul/div)
- ResultSrcE, in, 2, execute result select
- PCSrcE/RegWriteE, in, 1, branch taken; execute writes Rd
- Rs1E/Rs2E/RdE, in, REG_ADDR_W, execute registers
- RegWriteM/MemBusyM, in, 1, memory writes Rd; data memory not ready
- RdM, in, REG_ADDR_W, memory destination
- RegWriteW, in, 1, writeback writes Rd
- RdW, in, REG_ADDR_W, writeback destination
- LongDoneValid, in, 1, long op completed this cycle
- LongDoneRd, in, REG_ADDR_W, completed destination
- StallF/StallD/StallE/StallM, out, 1, stage hold
- FlushD/FlushE/FlushW, out, 1, stage bubble
- ForwardAE/ForwardBE, out, 2, operand forward select
- SbFull, out, 1, MAX_PENDING outstanding
- StallCycles/FlushCycles, out, CNT_W, perf counters (macro-gated)

Function
REQ-003 lwStall SHALL be ResultSrcE==RESULT_MEM & RdE!=0 & ((UsesRs1D & Rs1D==RdE) | (UsesRs2D & Rs2D==RdE)).
REQ-004 sbStall SHALL assert when: a used source register is pending; or LongOpD & RegWriteD & pending[RdD] (WAW); or LongOpD & SbFull.
REQ-005 A completion in the same cycle SHALL NOT release sbStall; release is the following cycle.
REQ-006 Without MemBusyM: StallF=StallD=lwStall|sbStall; FlushD=PCSrcE; FlushE=lwStall|sbStall|PCSrcE; StallE=StallM=FlushW=0.
REQ-007 MemBusyM SHALL override: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; a pending PCSrcE flush applies on the first non-busy cycle.
REQ-008 Issue SHALL be LongOpD & RegWriteD & RdD!=0 & !StallD & !FlushE & !MemBusyM; issue sets pending[RdD] and increments count at the next edge.
REQ-009 LongDoneValid with pending[LongDoneRd] set SHALL clear it and decrement count; a completion for a non-pending register SHALL be ignored (no underflow).
REQ-010 Simultaneous issue and completion SHALL leave count unchanged; register 0 is never pending.
REQ-011 SbFull SHALL equal count==MAX_PENDING, registered.
REQ-012 ForwardAE SHALL be FWD_MEM (2'b10) if RegWriteM & RdM==Rs1E & Rs1E!=0; else FWD_WB (2'b01) if RegWriteW & RdW==Rs1E & Rs1E!=0; else FWD_NONE (2'b00); ForwardBE is identical on Rs2E. Both are combinational and zero-latency.

Reset
REQ-013 reset SHALL clear all pending bits, count, SbFull and counters at the next edge; completions after reset SHALL be ignored per REQ-009.
REQ-014 During reset, combinational outputs SHALL follow inputs, with scoreboard terms zero.

Configuration
REQ-015 With HAZARD_UNIT_PERF_EN defined:
- StallCycles increments on StallD.
- FlushCycles increments on FlushD|FlushE.
- Both saturate at all-ones.
REQ-016 Without HAZARD_UNIT_PERF_EN, both counters SHALL be tied to 0 and no counter flops synthesised.

Structure
REQ-017 Package riscv_pkg SHALL hold RESULT_ALU/RESULT_MEM/RESULT_PC4, FWD_NONE/FWD_WB/FWD_MEM and REG_ADDR_W.
REQ-018 Pending vector and count SHALL live in sub-module hazard_scoreboard; forwarding and stall/flush logic stay in hazard_unit_sb.

Verification
REQ-019 Load x5 in E (ResultSrcE=01, RdE=5), Rs1D=5, UsesRs1D=1 -> StallF=StallD=FlushE=1, one cycle.
REQ-020 Issue mul to x7; next instruction reads x7 -> StallD held until the cycle after LongDoneValid, LongDoneRd=7.
REQ-021 Issue 4 long ops to x1..x4, then LongOpD -> SbFull=1, StallD=1; one completion -> issue proceeds the cycle after.
REQ-022 RegWriteM=1, RdM=3; RegWriteW=1, RdW=3; Rs1E=3 -> ForwardAE=10; Rs2E=0, RdM=0 -> ForwardBE=00.
REQ-023 PCSrcE=1 with MemBusyM=1 for 3 cycles -> all stalls=1, FlushD=0 for 3 cycles, then FlushD=FlushE=1 in the first non-busy cycle.
REQ-024 reset with 2 pending, then LongDoneValid, LongDoneRd=1 -> count stays 0, no stall.
